// File: rtl/hazard_ctl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctl.
// Carries the decode/execute/memory hazard sources into the controller and
// the stall/flush/busy/statistics outputs back to the pipeline.
//   master : pipeline side (drives hazard sources, observes controls)
//   slave  : hazard_ctl side
interface hazard_ctl_if;
  logic [4:0]  SrcA_ID;
  logic [4:0]  SrcB_ID;
  logic        UsesB_ID;
  logic [4:0]  LoadDst_EX;
  logic        LoadValid_EX;
  logic        MduStart_ID;
  logic        MduRead_ID;
  logic        Jump_IDM1;
  logic        BranchTaken_EXM1;
  logic        MemReq_ME;
  logic        MemReady_ME;
  logic        ClrStat;
  logic        AnyStall;
  logic        Stall_IF;
  logic        Stall_ID;
  logic        Flush_ID;
  logic        Flush_EX;
  logic        MduBusy;
  logic [15:0] StallCycles;

  modport master (
    output SrcA_ID, SrcB_ID, UsesB_ID, LoadDst_EX, LoadValid_EX,
           MduStart_ID, MduRead_ID, Jump_IDM1, BranchTaken_EXM1,
           MemReq_ME, MemReady_ME, ClrStat,
    input  AnyStall, Stall_IF, Stall_ID, Flush_ID, Flush_EX,
           MduBusy, StallCycles
  );

  modport slave (
    input  SrcA_ID, SrcB_ID, UsesB_ID, LoadDst_EX, LoadValid_EX,
           MduStart_ID, MduRead_ID, Jump_IDM1, BranchTaken_EXM1,
           MemReq_ME, MemReady_ME, ClrStat,
    output AnyStall, Stall_IF, Stall_ID, Flush_ID, Flush_EX,
           MduBusy, StallCycles
  );
endinterface

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller.
// Resolves, in priority order: memory wait (global freeze), branch/jump
// redirect flushes, multiply/divide unit occupancy stalls and load-use stalls.
// Tracks the MDU with a two-state FSM and a latency down-counter, and keeps a
// saturating count of stalled cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   hif    : hazard_ctl_if.slave (hazard sources in, stall/flush/status out)
// Parameter:
//   MDU_LAT : multiply/divide latency in cycles (2..32)
module hazard_ctl #(
  parameter int unsigned MDU_LAT = 8
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctl_if.slave   hif
);

  typedef enum logic {
    IDLE    = 1'b0,
    MDU_RUN = 1'b1
  } state_t;

  localparam logic [4:0] CNT_LOAD = 5'(MDU_LAT - 1);

  state_t      state, state_nxt;
  logic [4:0]  mdu_cnt, mdu_cnt_nxt;
  logic [15:0] stall_cycles;

  logic any_stall;
  logic load_use;
  logic mdu_haz;
  logic stall_if, stall_id, flush_id, flush_ex;

  assign any_stall = hif.MemReq_ME & ~hif.MemReady_ME;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = hif.LoadValid_EX && (hif.LoadDst_EX != 5'd0) &&
                    ((hif.LoadDst_EX == hif.SrcA_ID) ||
                     (hif.UsesB_ID && (hif.LoadDst_EX == hif.SrcB_ID)));

  assign mdu_haz = (state == MDU_RUN) && (hif.MduRead_ID || hif.MduStart_ID);

  // Pipeline controls. Reset and the global freeze both mask every local
  // stall/flush; branch outranks jump when both redirect in the same cycle.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (reset || any_stall) begin
      // all local controls held low
    end else if (hif.BranchTaken_EXM1) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (hif.Jump_IDM1) begin
      flush_id = 1'b1;
    end else if (mdu_haz || load_use) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // MDU next state: a start is accepted only in a cycle with no freeze,
  // stall or flush, so a flushed or stalled mult/div never occupies the unit.
  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    unique case (state)
      IDLE: begin
        if (hif.MduStart_ID && !(any_stall || stall_id || flush_id || flush_ex)) begin
          state_nxt   = MDU_RUN;
          mdu_cnt_nxt = CNT_LOAD;
        end
      end
      MDU_RUN: begin
        // Counts down regardless of pipeline freezes: the unit runs on its own.
        if (mdu_cnt == 5'd0) begin
          state_nxt = IDLE;
        end else begin
          mdu_cnt_nxt = mdu_cnt - 5'd1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        mdu_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (hif.ClrStat) begin
      stall_cycles <= '0;
    end else if ((any_stall || stall_id) && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign hif.AnyStall    = any_stall;
  assign hif.Stall_IF    = stall_if;
  assign hif.Stall_ID    = stall_id;
  assign hif.Flush_ID    = flush_id;
  assign hif.Flush_EX    = flush_ex;
  assign hif.MduBusy     = (state == MDU_RUN);
  assign hif.StallCycles = stall_cycles;

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl (MDU_LAT = 8).
// Stimulus applies inputs 1 ns after each rising edge and queues the
// hand-computed expected controls; the monitor checks them on the falling edge.
module tb_hazard_ctl;

  logic clk;
  logic reset;

  hazard_ctl_if hif ();

  hazard_ctl #(.MDU_LAT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {AnyStall, Stall_IF, Stall_ID, Flush_ID, Flush_EX, MduBusy}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_ANY   = 6'b100000;
  localparam logic [5:0] F_STALL = 6'b011010;
  localparam logic [5:0] F_BR    = 6'b000110;
  localparam logic [5:0] F_JMP   = 6'b000100;
  localparam logic [5:0] F_BUSY  = 6'b000001;

  typedef struct {
    string       nm;
    logic [5:0]  f;
    logic [15:0] sc;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sc_exp   = '0;

  task automatic clr_in();
    hif.SrcA_ID          = '0;
    hif.SrcB_ID          = '0;
    hif.UsesB_ID         = 1'b0;
    hif.LoadDst_EX       = '0;
    hif.LoadValid_EX     = 1'b0;
    hif.MduStart_ID      = 1'b0;
    hif.MduRead_ID       = 1'b0;
    hif.Jump_IDM1        = 1'b0;
    hif.BranchTaken_EXM1 = 1'b0;
    hif.MemReq_ME        = 1'b0;
    hif.MemReady_ME      = 1'b0;
    hif.ClrStat          = 1'b0;
  endtask

  task automatic load_use_a(input logic [4:0] r);
    hif.LoadValid_EX = 1'b1;
    hif.LoadDst_EX   = r;
    hif.SrcA_ID      = r;
  endtask

  // Inputs are already applied; queue expectation, then advance one cycle
  // and update the statistics model from the expected stall flags.
  task automatic cyc(input string nm, input logic [5:0] f);
    exp_t e;
    if (reset) sc_exp = '0;
    e.nm = nm;
    e.f  = f;
    e.sc = sc_exp;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (hif.ClrStat) sc_exp = '0;
    else if ((f[5] || f[3]) && sc_exp != 16'hFFFF) sc_exp = sc_exp + 16'd1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e   = q.pop_front();
      act = {hif.AnyStall, hif.Stall_IF, hif.Stall_ID, hif.Flush_ID, hif.Flush_EX, hif.MduBusy};
      checks++;
      if (act !== e.f) begin
        failures++;
        $display("FAIL %s flags: got %b expected %b", e.nm, act, e.f);
      end
      checks++;
      if (hif.StallCycles !== e.sc) begin
        failures++;
        $display("FAIL %s StallCycles: got %h expected %h", e.nm, hif.StallCycles, e.sc);
      end
    end
  end

  initial begin
    clr_in();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Controls masked during reset; AnyStall still combinational.
    load_use_a(5'd5);
    hif.MemReq_ME = 1'b1;
    cyc("rst_outputs", F_ANY);
    hif.MemReq_ME = 1'b0;
    cyc("rst_outputs_quiet", F_NONE);
    reset = 1'b0;
    clr_in();
    cyc("idle", F_NONE);

    // Load-use detection.
    load_use_a(5'd5);
    cyc("lu_rs", F_STALL);
    clr_in();
    cyc("lu_release", F_NONE);
    load_use_a(5'd0);
    cyc("lu_r0", F_NONE);
    clr_in();
    hif.LoadValid_EX = 1'b1; hif.LoadDst_EX = 5'd7; hif.SrcA_ID = 5'd3;
    hif.SrcB_ID = 5'd7; hif.UsesB_ID = 1'b1;
    cyc("lu_rt", F_STALL);
    hif.UsesB_ID = 1'b0;
    cyc("lu_rt_unused", F_NONE);
    load_use_a(5'd9); hif.LoadValid_EX = 1'b0;
    cyc("lu_not_load", F_NONE);

    // Redirect priority.
    load_use_a(5'd5); hif.BranchTaken_EXM1 = 1'b1;
    cyc("lu_branch", F_BR);
    hif.BranchTaken_EXM1 = 1'b0; hif.Jump_IDM1 = 1'b1;
    cyc("lu_jump", F_JMP);
    hif.BranchTaken_EXM1 = 1'b1;
    cyc("branch_jump", F_BR);
    clr_in();

    // Flushed or stalled starts must not occupy the unit.
    hif.MduStart_ID = 1'b1; hif.Jump_IDM1 = 1'b1;
    cyc("start_jumped", F_JMP);
    clr_in();
    cyc("no_busy_after_jump", F_NONE);
    hif.MduStart_ID = 1'b1; load_use_a(5'd4);
    cyc("start_lu", F_STALL);
    clr_in();
    cyc("no_busy_after_lu", F_NONE);
    hif.MduStart_ID = 1'b1; hif.MemReq_ME = 1'b1;
    cyc("start_frozen", F_ANY);
    clr_in();
    cyc("no_busy_after_freeze", F_NONE);

    // mult at T, busy T+1..T+8, mflo from T+3 stalls through T+8.
    hif.MduStart_ID = 1'b1;
    cyc("mult_T", F_NONE);
    clr_in();
    cyc("busy_T1", F_BUSY);
    cyc("busy_T2", F_BUSY);
    hif.MduRead_ID = 1'b1;
    for (int i = 3; i <= 8; i++) cyc($sformatf("mflo_T%0d", i), F_STALL | F_BUSY);
    cyc("mflo_T9", F_NONE);
    clr_in();

    // Memory freeze during MDU_RUN: counter keeps running.
    hif.MduStart_ID = 1'b1;
    cyc("mult2_T", F_NONE);
    clr_in();
    cyc("mult2_T1", F_BUSY);
    hif.MemReq_ME = 1'b1; hif.MduRead_ID = 1'b1;
    cyc("mem_T2", F_ANY | F_BUSY);
    cyc("mem_T3", F_ANY | F_BUSY);
    cyc("mem_T4", F_ANY | F_BUSY);
    hif.MemReady_ME = 1'b1; hif.MduRead_ID = 1'b0;
    cyc("mem_ready_T5", F_BUSY);
    clr_in();
    hif.BranchTaken_EXM1 = 1'b1; hif.MduRead_ID = 1'b1;
    cyc("br_busy_T6", F_BR | F_BUSY);
    clr_in();
    hif.MduStart_ID = 1'b1;
    cyc("start_busy_T7", F_STALL | F_BUSY);
    clr_in();
    cyc("mult2_T8", F_BUSY);
    cyc("mult2_T9", F_NONE);

    // Reset mid-operation abandons the unit immediately.
    hif.MduStart_ID = 1'b1;
    cyc("mult3_T", F_NONE);
    clr_in();
    cyc("mult3_T1", F_BUSY);
    cyc("mult3_T2", F_BUSY);
    cyc("mult3_T3", F_BUSY);
    reset = 1'b1;
    cyc("mult3_reset", F_NONE);
    reset = 1'b0;
    hif.MduRead_ID = 1'b1;
    cyc("mflo_after_reset", F_NONE);
    clr_in();

    // Saturation and clear.
    hif.MemReq_ME = 1'b1;
    for (int i = 0; i < 65537; i++) cyc("sat_run", F_ANY);
    cyc("sat_hold", F_ANY);
    hif.ClrStat = 1'b1;
    cyc("clr_with_stall", F_ANY);
    clr_in();
    cyc("cleared", F_NONE);
    hif.ClrStat = 1'b1;
    cyc("clr_idle", F_NONE);
    clr_in();
    cyc("end", F_NONE);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 8: multiply/divide latency in cycles, legal range 2..32.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port SrcA_ID  input  5  rs of the instruction in decode.
REQ-005 SHALL have port SrcB_ID  input  5  rt of the instruction in decode.
REQ-006 SHALL have port UsesB_ID  input  1  decode instruction reads rt.
REQ-007 SHALL have port LoadDst_EX  input  5  destination register of the instruction in execute.
REQ-008 SHALL have port LoadValid_EX  input  1  execute instruction is a load (MemToReg).
REQ-009 SHALL have port MduStart_ID  input  1  decode instruction is mult/multu/div/divu.
REQ-010 SHALL have port MduRead_ID  input  1  decode instruction is mfhi/mflo.
REQ-011 SHALL have port Jump_IDM1  input  1  jump redirect this cycle.
REQ-012 SHALL have port BranchTaken_EXM1  input  1  taken-branch redirect this cycle.
REQ-013 SHALL have port MemReq_ME, MemReady_ME  input  1 each  memory access pending / completing.
REQ-014 SHALL have port ClrStat  input  1  synchronous clear of StallCycles.
REQ-015 SHALL have port AnyStall  output  1  freeze all pipeline registers.
REQ-016 SHALL have port Stall_IF, Stall_ID  output  1 each  hold fetch PC / decode register.
REQ-017 SHALL have port Flush_ID, Flush_EX  output  1 each  insert bubble into decode / execute register.
REQ-018 SHALL have port MduBusy  output  1  multiply/divide unit occupied.
REQ-019 SHALL have port StallCycles  output  16  saturating count of stalled cycles.

Function
REQ-020 AnyStall SHALL be combinational: MemReq_ME & ~MemReady_ME.
REQ-021 Priority SHALL be AnyStall > redirect flush > MDU stall > load-use stall; when AnyStall=1, Stall_IF, Stall_ID, Flush_ID and Flush_EX SHALL all be 0.
REQ-022 Load-use: LoadValid_EX & LoadDst_EX!=0 & (LoadDst_EX==SrcA_ID | (UsesB_ID & LoadDst_EX==SrcB_ID)) SHALL assert Stall_IF=Stall_ID=Flush_EX=1 for exactly that cycle.
REQ-023 Register 0 SHALL never cause a load-use hazard.
REQ-024 BranchTaken_EXM1=1 SHALL assert Flush_ID=Flush_EX=1 and deassert Stall_IF/Stall_ID that cycle.
REQ-025 Jump_IDM1=1 (no branch) SHALL assert Flush_ID=1 only; stalls suppressed that cycle.
REQ-026 Simultaneous BranchTaken_EXM1 and Jump_IDM1 SHALL be treated as branch (REQ-024).
REQ-027 FSM SHALL have states IDLE and MDU_RUN, plus a 5-bit down-counter MduCnt.
REQ-028 IDLE->MDU_RUN SHALL occur when MduStart_ID=1 and no stall/flush/AnyStall is asserted that cycle; MduCnt loads MDU_LAT-1.
REQ-029 In MDU_RUN, MduCnt SHALL decrement every cycle, including AnyStall cycles; at MduCnt==0 the FSM returns to IDLE next edge.
REQ-030 MduBusy SHALL equal (state==MDU_RUN), giving exactly MDU_LAT busy cycles per operation.
REQ-031 While MduBusy=1, MduRead_ID or MduStart_ID SHALL assert Stall_IF=Stall_ID=Flush_EX=1.
REQ-032 A flushed MduStart_ID (REQ-024/025 same cycle) SHALL NOT start the unit.
REQ-033 StallCycles SHALL increment by 1 each cycle AnyStall|Stall_ID is 1, saturate at 0xFFFF, and clear to 0 on ClrStat (clear wins over increment).

Reset
REQ-034 reset=1 SHALL immediately force state=IDLE, MduCnt=0, MduBusy=0, StallCycles=0.
REQ-035 During reset, Stall_IF, Stall_ID, Flush_ID, Flush_EX SHALL be 0; AnyStall follows REQ-020.
REQ-036 Reset asserted mid-MDU_RUN SHALL abandon the operation; no residual busy after release.

Verification
REQ-037 Load r5 in EX, decode reads rs=5 -> one cycle Stall_IF=Stall_ID=Flush_EX=1; LoadDst_EX=0 -> no stall.
REQ-038 MDU_LAT=8, mult accepted at cycle T -> MduBusy=1 for T+1..T+8; mflo at T+3 stalls through T+8, released T+9.
REQ-039 Load-use hazard and BranchTaken_EXM1 same cycle -> Flush_ID=Flush_EX=1, Stall_IF=Stall_ID=0.
REQ-040 MemReq_ME=1, MemReady_ME=0 for 3 cycles during MDU_RUN -> AnyStall=1 three cycles, MduCnt still decrements, StallCycles +3.
REQ-041 StallCycles preset to 0xFFFE via 2+ stall cycles -> holds 0xFFFF; ClrStat with stall -> 0.
REQ-042 reset pulse at MduCnt=4 -> MduBusy=0 asynchronously, next mflo not stalled.
